// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: round-robin share of one uart_tx among NUM_CH requesters, sending 5-byte framed samples
module uart_frame_arbiter #(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*16-1:0] req_data,
  output logic [NUM_CH-1:0]    ack,
  output logic                 frame_done,
  output logic                 arb_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
  state_t state;
  logic [2:0] last_grant, ch, win, byte_idx;
  logic [1:0] guard;
  logic [15:0] sample, win_data;
  logic [NUM_CH-1:0] pick;
  logic found;
  logic [7:0] cur_byte, csum;
  // round-robin pick: channels above last_grant outrank those at or below it, lowest index first within each group
  always_comb begin
    win = '0;
    win_data = '0;
    pick = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i] && i <= int'(last_grant)) begin
        win = 3'(i);
        win_data = req_data[16*i +: 16];
        pick = '0;
        pick[i] = 1'b1;
        found = 1'b1;
      end
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i] && i > int'(last_grant)) begin
        win = 3'(i);
        win_data = req_data[16*i +: 16];
        pick = '0;
        pick[i] = 1'b1;
        found = 1'b1;
      end
  end
  assign csum = SYNC_BYTE ^ {5'b0, ch} ^ sample[15:8] ^ sample[7:0];
  assign cur_byte = byte_idx == 3'd0 ? SYNC_BYTE :
                    byte_idx == 3'd1 ? {5'b0, ch} :
                    byte_idx == 3'd2 ? sample[15:8] :
                    byte_idx == 3'd3 ? sample[7:0] : csum;
  // frame controller: grant, then per byte start, wait busy rise (with resend guard), wait busy fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_CH - 1);
      ch         <= '0;
      sample     <= '0;
      byte_idx   <= '0;
      guard      <= '0;
      ack        <= '0;
      frame_done <= 1'b0;
      arb_busy   <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      ack        <= '0;
      frame_done <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        IDLE: begin
          arb_busy <= found && !tx_busy;
          if (found && !tx_busy) begin
            last_grant <= win;
            ch         <= win;
            sample     <= win_data;
            ack        <= pick;
            byte_idx   <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          tx_data  <= cur_byte;
          tx_start <= 1'b1;
          guard    <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
          else if (guard == 2'd3) state <= SEND;
          else guard <= guard + 2'd1;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (byte_idx == 3'd4) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb_uart_frame_arbiter: vector table, corner sequences and randomized run against a round-robin frame model
module tb_uart_frame_arbiter;
  localparam int N  = 4;
  localparam int BL = 10;
  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
    logic [39:0] eb;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] req_data = '0;
  logic [3:0] ack;
  logic frame_done, arb_busy, tx_start, tx_busy;
  logic [7:0] tx_data;
  int n_chk = 0, n_fail = 0;
  logic [7:0] got[$];
  int st_cyc[$];
  logic [3:0] ack_q[$];
  logic [39:0] exp_q[$];
  int cyc = 0, ns = 0, drop_at = -1, bcnt = 0;
  vec_t tab[5];

  uart_frame_arbiter #(.NUM_CH(N), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .frame_done(frame_done), .arb_busy(arb_busy), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  assign tx_busy = bcnt != 0;

  // uart_tx stand-in: busy for BL cycles starting the cycle after tx_start; can ignore one chosen start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    else if (tx_start) begin
      ns <= ns + 1;
      if (ns != drop_at) bcnt <= BL;
    end
  end

  // record every byte handed to uart_tx and every grant
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      got.push_back(tx_data);
      st_cyc.push_back(cyc);
    end
    if (ack != 0) ack_q.push_back(ack);
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, a, e);
    end
  endtask

  function automatic logic [39:0] mk(input int c, input logic [15:0] d);
    logic [7:0] b1;
    b1 = 8'(c);
    return {8'hAA, b1, d, 8'hAA ^ b1 ^ d[15:8] ^ d[7:0]};
  endfunction

  function automatic int rr(input int last, input logic [3:0] r);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ack"}, ack, 0);
    chk({nm, "_fd"}, frame_done, 0);
    chk({nm, "_busy"}, arb_busy, 0);
    chk({nm, "_start"}, tx_start, 0);
    chk({nm, "_data"}, tx_data, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    @(negedge clk); #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got.delete(); st_cyc.delete(); ack_q.delete(); exp_q.delete();
  endtask

  task automatic wait_ack(input int n, input string nm);
    for (int k = 0; k < 800 && ack_q.size() < n; k++) begin
      @(negedge clk); #1;
    end
    chk({nm, "_ack_seen"}, ack_q.size() >= n, 1);
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (frame_done) break;
    end
    chk({nm, "_done"}, frame_done, 1);
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (!arb_busy && !tx_busy) break;
    end
    chk({nm, "_idle"}, arb_busy, 0);
  endtask

  task automatic cmp_frame(input string nm, input logic [39:0] eb, input int off);
    chk({nm, "_len"}, got.size() >= off + 5, 1);
    for (int i = 0; i < 5; i++)
      if (got.size() > off + i) chk($sformatf("%s_b%0d", nm, i), got[off+i], eb[39-8*i -: 8]);
  endtask

  task automatic run_frame(input logic [3:0] r, input logic [63:0] d, input logic [39:0] eb, input string nm);
    @(posedge clk); #1;
    req = r;
    req_data = d;
    got.delete();
    ack_q.delete();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (ack != 0) break;
    end
    chk({nm, "_ack"}, ack, r);
    @(negedge clk); #1;
    chk({nm, "_ackw"}, ack, 0);
    chk({nm, "_start"}, tx_start, 1);
    req = '0;
    wait_done(nm);
    chk({nm, "_busy_at_done"}, arb_busy, 1);
    cmp_frame(nm, eb, 0);
    chk({nm, "_nbytes"}, got.size(), 5);
    @(negedge clk); #1;
    chk({nm, "_fd_pulse"}, frame_done, 0);
    chk({nm, "_idle"}, arb_busy, 0);
  endtask

  initial begin
    logic [63:0] dall, prev_data;
    logic [3:0] prev_req;
    logic [39:0] ef;
    logic pend;
    int m_last, w;
    tab[0] = '{4'b0100, 16'h1234, 40'hAA_02_12_34_8E};
    tab[1] = '{4'b0001, 16'h0000, 40'hAA_00_00_00_AA};
    tab[2] = '{4'b1000, 16'hFFFF, 40'hAA_03_FF_FF_A9};
    tab[3] = '{4'b0010, 16'h1111, 40'hAA_01_11_11_AB};
    tab[4] = '{4'b0010, 16'hABCD, 40'hAA_01_AB_CD_CD};
    repeat (2) @(negedge clk);
    do_reset();
    for (int v = 0; v < 5; v++) begin
      dall = {$urandom, $urandom};
      for (int i = 0; i < N; i++) if (tab[v].r[i]) dall[16*i +: 16] = tab[v].d;
      run_frame(tab[v].r, dall, tab[v].eb, $sformatf("vec%0d", v));
    end
    do_reset();
    @(posedge clk); #1;
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req = 4'hF;
    wait_ack(5, "all");
    for (int v = 0; v < 5; v++)
      chk($sformatf("all_order%0d", v), ack_q.size() > v ? ack_q[v] : 4'h0, 4'b1 << (v % N));
    cmp_frame("all_ch0", 40'hAA_00_00_00_AA, 0);
    cmp_frame("all_ch1", 40'hAA_01_11_11_AB, 5);
    req = '0;
    wait_idle("all");
    do_reset();
    @(posedge clk); #1;
    req_data = {$urandom, $urandom};
    req = 4'b0001;
    wait_ack(1, "fair");
    @(posedge clk); #1;
    req[3] = 1'b1;
    wait_ack(3, "fair");
    chk("fair_ch3_next", ack_q.size() > 1 ? ack_q[1] : 4'h0, 4'b1000);
    chk("fair_ch0_after", ack_q.size() > 2 ? ack_q[2] : 4'h0, 4'b0001);
    req = '0;
    wait_idle("fair");
    @(posedge clk); #1;
    got.delete(); ack_q.delete();
    req_data[31:16] = 16'h5678;
    req = 4'b0010;
    wait_ack(1, "chg");
    req = '0;
    for (int k = 0; k < 300 && got.size() < 3; k++) begin
      @(negedge clk); #1;
    end
    req_data[31:16] = 16'hFFFF;
    wait_done("chg");
    cmp_frame("chg", 40'hAA_01_56_78_85, 0);
    wait_idle("chg");
    @(posedge clk); #1;
    got.delete(); ack_q.delete();
    req_data[47:32] = 16'hCAFE;
    req = 4'b0100;
    wait_ack(1, "rstmid");
    req = '0;
    for (int k = 0; k < 400 && got.size() < 4; k++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid_inflight", arb_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid_now");
    @(negedge clk); #1;
    chk_reset_vals("rstmid_low");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(4'b0001, {48'h0, 16'hBEEF}, 40'hAA_00_BE_EF_FB, "post_rst");
    wait_idle("miss_pre");
    drop_at = ns;
    @(posedge clk); #1;
    got.delete(); st_cyc.delete(); ack_q.delete();
    req_data[31:16] = 16'h00FF;
    req = 4'b0010;
    wait_ack(1, "miss");
    req = '0;
    wait_done("miss");
    chk("miss_nstarts", got.size(), 6);
    chk("miss_first", got.size() > 0 ? got[0] : 8'h0, 8'hAA);
    chk("miss_gap", st_cyc.size() > 1 ? st_cyc[1] - st_cyc[0] : 0, 5);
    cmp_frame("miss", 40'hAA_01_00_FF_54, 1);
    drop_at = -1;
    wait_idle("miss");
    do_reset();
    m_last = N - 1;
    pend = 1'b0;
    prev_req = '0;
    prev_data = '0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && t < 2700 && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b1;
          req_data[16*i +: 16] = 16'($urandom);
        end else if (req[i] && $urandom_range(0, 199) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req_data[16*i +: 16] = 16'($urandom);
      end
      @(negedge clk); #1;
      if (pend) chk("rand_liveness", ack != 0, 1);
      if (ack != 0) begin
        w = rr(m_last, prev_req);
        chk("rand_grant", ack, w < 0 ? 64'd0 : 64'd1 << w);
        if (w >= 0) begin
          exp_q.push_back(mk(w, prev_data[16*w +: 16]));
          m_last = w;
        end
      end
      if (frame_done) begin
        chk("rand_expected_frame", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ef = exp_q.pop_front();
          cmp_frame("rand", ef, 0);
          chk("rand_nbytes", got.size(), 5);
        end
        got.delete();
      end
      pend = !arb_busy && (req != 0) && !tx_busy;
      prev_req = req;
      prev_data = req_data;
    end
    wait_idle("rand_end");
    chk("rand_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
